// File: rtl/ps2_host_tx_if.sv
// Command handshake between the CPU-side register block and the PS/2 host transmitter.
//   tx_data   : byte to send, captured when tx_req is accepted
//   tx_req    : one-cycle request strobe
//   tx_busy   : transmitter owns the PS/2 lines
//   tx_done   : one-cycle pulse, byte acknowledged by the device
//   tx_error  : one-cycle pulse, timeout or missing acknowledge
//   tx_active : copy of tx_busy for the receive path
// master = requester (CPU side), slave = transmitter.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_req;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_error;
   logic       tx_active;

   modport master (
      output tx_data, tx_req,
      input  tx_busy, tx_done, tx_error, tx_active
   );

   modport slave (
      input  tx_data, tx_req,
      output tx_busy, tx_done, tx_error, tx_active
   );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Sends one command byte to a keyboard or mouse using the
// request-to-send sequence: hold clock low, pull data low, release clock, then present the data
// bits, odd parity and stop bit on device-generated clock falls and check the device's ack.
// Ports:
//   clk, reset_n            : system clock, asynchronous active-low reset
//   tx                      : command handshake (ps2_host_tx_if.slave)
//   ps2_clk_in, ps2_dat_in  : raw PS/2 pins
//   ps2_clk_oe, ps2_dat_oe  : open-collector enables, 1 pulls the line low
module ps2_host_tx #(
   parameter int unsigned SYSCLK_FREQUENCY = 1250,  // units of 100 kHz
   parameter int unsigned INHIBIT_US       = 100,
   parameter int unsigned TIMEOUT_US       = 2000
) (
   input  logic         clk,
   input  logic         reset_n,
   ps2_host_tx_if.slave tx,
   input  logic         ps2_clk_in,
   input  logic         ps2_dat_in,
   output logic         ps2_clk_oe,
   output logic         ps2_dat_oe
);

   localparam int unsigned InhibitCycles = SYSCLK_FREQUENCY * INHIBIT_US / 10;
   localparam int unsigned TimeoutCycles = SYSCLK_FREQUENCY * TIMEOUT_US / 10;
   localparam int unsigned MaxCycles     = (InhibitCycles > TimeoutCycles) ?
                                           InhibitCycles : TimeoutCycles;
   localparam int unsigned TimerWidth    = $clog2(MaxCycles + 1);

   // The timer is checked for zero before decrementing, so load N-1 for N cycles.
   localparam logic [TimerWidth-1:0] InhibitLoad = TimerWidth'(InhibitCycles - 1);
   localparam logic [TimerWidth-1:0] TimeoutLoad = TimerWidth'(TimeoutCycles - 1);

   typedef enum logic [2:0] {
      StIdle, StInhibit, StReq, StData, StAck, StWaitIdle
   } state_e;

   state_e                state_q;
   logic [8:0]            shreg_q;
   logic [3:0]            bitcnt_q;
   logic [TimerWidth-1:0] timer_q;
   logic                  busy_q, done_q, err_q, clk_oe_q, dat_oe_q;

   logic clk_meta_q, clk_sync_q, clk_prev_q;
   logic dat_meta_q, dat_sync_q;
   logic fall, timer_zero, fail;

   // Synchronisers idle high (pulled-up lines) so reset never fakes a falling edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
      end else begin
         clk_meta_q <= ps2_clk_in;
         clk_sync_q <= clk_meta_q;
         clk_prev_q <= clk_sync_q;
         dat_meta_q <= ps2_dat_in;
         dat_sync_q <= dat_meta_q;
      end
   end

   assign fall       = clk_prev_q & ~clk_sync_q;
   assign timer_zero = (timer_q == '0);

   // Abort conditions: watchdog expiry once the device owns the clock, or no ack at fall 11.
   always_comb begin
      fail = 1'b0;
      case (state_q)
         StData:     fail = !fall && timer_zero;
         StAck:      fail = fall ? dat_sync_q : timer_zero;
         StWaitIdle: fail = !(clk_sync_q && dat_sync_q) && timer_zero;
         default:    fail = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         timer_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         clk_oe_q <= 1'b0;
         dat_oe_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (fail) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b1;
            state_q  <= StIdle;
         end else begin
            unique case (state_q)
               StIdle: begin
                  // Requests arriving while busy never reach here, so they are dropped.
                  if (tx.tx_req) begin
                     shreg_q  <= {~^tx.tx_data, tx.tx_data};
                     bitcnt_q <= '0;
                     timer_q  <= InhibitLoad;
                     busy_q   <= 1'b1;
                     clk_oe_q <= 1'b1;
                     dat_oe_q <= 1'b0;
                     state_q  <= StInhibit;
                  end
               end
               StInhibit: begin
                  if (timer_zero) begin
                     clk_oe_q <= 1'b0;
                     dat_oe_q <= 1'b1;  // start bit
                     state_q  <= StReq;
                  end else begin
                     timer_q <= timer_q - 1'b1;
                  end
               end
               StReq: begin
                  timer_q <= TimeoutLoad;
                  state_q <= StData;
               end
               StData: begin
                  if (fall) begin
                     bitcnt_q <= bitcnt_q + 4'd1;
                     timer_q  <= TimeoutLoad;
                     if (bitcnt_q == 4'd9) begin
                        dat_oe_q <= 1'b0;  // stop bit
                        state_q  <= StAck;
                     end else begin
                        // Falls 1..9 present data LSB first, then parity.
                        dat_oe_q <= ~shreg_q[0];
                        shreg_q  <= {1'b0, shreg_q[8:1]};
                     end
                  end else begin
                     timer_q <= timer_q - 1'b1;
                  end
               end
               StAck: begin
                  if (fall) begin
                     bitcnt_q <= bitcnt_q + 4'd1;
                     timer_q  <= TimeoutLoad;
                     state_q  <= StWaitIdle;
                  end else begin
                     timer_q <= timer_q - 1'b1;
                  end
               end
               StWaitIdle: begin
                  if (clk_sync_q && dat_sync_q) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= StIdle;
                  end else begin
                     timer_q <= timer_q - 1'b1;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign tx.tx_busy   = busy_q;
   assign tx.tx_active = busy_q;
   assign tx.tx_done   = done_q;
   assign tx.tx_error  = err_q;
   assign ps2_clk_oe   = clk_oe_q;
   assign ps2_dat_oe   = dat_oe_q;

endmodule
